// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// ---------------------------------------------------------------------------
// tt_um_jleugeri_ttt_pkg
// Shared definitions for the event-network consumer (demux) side:
//   - state_t   : demux FSM states
//   - idx_width : index width derived from the processor count
//   - sat_add   : signed saturating add into a w-bit two's-complement range
// ---------------------------------------------------------------------------
package tt_um_jleugeri_ttt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SCAN,
      ST_NEXT,
      ST_FLUSH
   } state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Result is clamped to [-2^(w-1), 2^(w-1)-1]; operands are plain ints so
   // the same function serves any counter or weight width.
   function automatic int sat_add(input int a, input int b, input int w);
      int lo;
      int hi;
      int s;
      lo = -(1 << (w - 1));
      hi = (1 << (w - 1)) - 1;
      s  = a + b;
      if (s > hi)
         return hi;
      else if (s < lo)
         return lo;
      else
         return s;
   endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_weights.sv
// ---------------------------------------------------------------------------
// tt_um_jleugeri_ttt_weights
// NUM_PROCESSORS x NUM_PROCESSORS register file of signed good/bad weights.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset (clears all)
//   i_we, i_wr_src, i_wr_tgt       synchronous write strobe and address
//   i_wr_good, i_wr_bad            write data
//   i_rd_src, i_rd_tgt             combinational read address
//   o_rd_good, o_rd_bad            read data (0 for out-of-range address)
// ---------------------------------------------------------------------------
module tt_um_jleugeri_ttt_weights
   import tt_um_jleugeri_ttt_pkg::*;
#(
   parameter int NUM_PROCESSORS = 10,
   parameter int WEIGHT_BITS    = 4,
   parameter int IDX_W          = idx_width(NUM_PROCESSORS)
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_we,
   input  logic        [IDX_W-1:0]       i_wr_src,
   input  logic        [IDX_W-1:0]       i_wr_tgt,
   input  logic signed [WEIGHT_BITS-1:0] i_wr_good,
   input  logic signed [WEIGHT_BITS-1:0] i_wr_bad,
   input  logic        [IDX_W-1:0]       i_rd_src,
   input  logic        [IDX_W-1:0]       i_rd_tgt,
   output logic signed [WEIGHT_BITS-1:0] o_rd_good,
   output logic signed [WEIGHT_BITS-1:0] o_rd_bad
);

   logic signed [WEIGHT_BITS-1:0] r_good [NUM_PROCESSORS][NUM_PROCESSORS];
   logic signed [WEIGHT_BITS-1:0] r_bad  [NUM_PROCESSORS][NUM_PROCESSORS];

   logic w_wr_ok;
   logic w_rd_ok;

   assign w_wr_ok = (int'(i_wr_src) < NUM_PROCESSORS) && (int'(i_wr_tgt) < NUM_PROCESSORS);
   assign w_rd_ok = (int'(i_rd_src) < NUM_PROCESSORS) && (int'(i_rd_tgt) < NUM_PROCESSORS);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int s = 0; s < NUM_PROCESSORS; s++) begin
            for (int t = 0; t < NUM_PROCESSORS; t++) begin
               r_good[s][t] <= '0;
               r_bad[s][t]  <= '0;
            end
         end
      end else if (i_we && w_wr_ok) begin
         r_good[i_wr_src][i_wr_tgt] <= i_wr_good;
         r_bad[i_wr_src][i_wr_tgt]  <= i_wr_bad;
      end
   end

   always_comb begin
      o_rd_good = '0;
      o_rd_bad  = '0;
      if (w_rd_ok) begin
         o_rd_good = r_good[i_rd_src][i_rd_tgt];
         o_rd_bad  = r_bad[i_rd_src][i_rd_tgt];
      end
   end

endmodule

// File: rtl/tt_um_jleugeri_ttt_demux.sv
// ---------------------------------------------------------------------------
// tt_um_jleugeri_ttt_demux
// Consumer/scatter side of the processor event network. Handshakes with the
// event mux (go_out/next_out), and for each source event walks all targets,
// accumulating +/- weights into saturating good/bad token counters. A scan
// round ends with a one-cycle enable pulse publishing the counters.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start_in                        start a scan round (IDLE only)
//   go_out, next_out                mux handshake pulses
//   hot_in, done_in, idx_in,
//   t_start_in, t_stop_in           event from the mux
//   prog_we, prog_src, prog_tgt,
//   prog_good_w, prog_bad_w         weight programming (IDLE only)
//   new_good_tokens, new_bad_tokens registered per-target token counts
//   enable                          one-cycle pulse: token outputs updated
// ---------------------------------------------------------------------------
module tt_um_jleugeri_ttt_demux
   import tt_um_jleugeri_ttt_pkg::*;
#(
   parameter int NUM_PROCESSORS  = 10,
   parameter int NEW_TOKENS_BITS = 4,
   parameter int WEIGHT_BITS     = 4,
   parameter int IDX_W           = idx_width(NUM_PROCESSORS)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start_in,
   output logic                              go_out,
   output logic                              next_out,
   input  logic                              hot_in,
   input  logic                              done_in,
   input  logic        [IDX_W-1:0]           idx_in,
   input  logic                              t_start_in,
   input  logic                              t_stop_in,
   input  logic                              prog_we,
   input  logic        [IDX_W-1:0]           prog_src,
   input  logic        [IDX_W-1:0]           prog_tgt,
   input  logic signed [WEIGHT_BITS-1:0]     prog_good_w,
   input  logic signed [WEIGHT_BITS-1:0]     prog_bad_w,
   output logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens [NUM_PROCESSORS],
   output logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens  [NUM_PROCESSORS],
   output logic                              enable
);

   state_t                            r_state;
   logic        [IDX_W-1:0]           r_src;
   logic        [IDX_W-1:0]           r_tgt;
   logic                              r_neg;
   logic signed [NEW_TOKENS_BITS-1:0] r_acc_good [NUM_PROCESSORS];
   logic signed [NEW_TOKENS_BITS-1:0] r_acc_bad  [NUM_PROCESSORS];

   logic                              w_we;
   logic signed [WEIGHT_BITS-1:0]     w_good_w;
   logic signed [WEIGHT_BITS-1:0]     w_bad_w;
   int                                w_eff_good;
   int                                w_eff_bad;
   int                                w_sum_good;
   int                                w_sum_bad;

   // Weights are only writable while no round is in flight.
   assign w_we = prog_we && (r_state == ST_IDLE);

   tt_um_jleugeri_ttt_weights #(
      .NUM_PROCESSORS (NUM_PROCESSORS),
      .WEIGHT_BITS    (WEIGHT_BITS),
      .IDX_W          (IDX_W)
   ) u_weights (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_we      (w_we),
      .i_wr_src  (prog_src),
      .i_wr_tgt  (prog_tgt),
      .i_wr_good (prog_good_w),
      .i_wr_bad  (prog_bad_w),
      .i_rd_src  (r_src),
      .i_rd_tgt  (r_tgt),
      .o_rd_good (w_good_w),
      .o_rd_bad  (w_bad_w)
   );

   // A stop event subtracts the weight. Negating the most negative weight
   // is clamped back into the weight range before the counter add.
   always_comb begin
      w_eff_good = int'(w_good_w);
      w_eff_bad  = int'(w_bad_w);
      if (r_neg) begin
         w_eff_good = sat_add(0, -int'(w_good_w), WEIGHT_BITS);
         w_eff_bad  = sat_add(0, -int'(w_bad_w), WEIGHT_BITS);
      end
      w_sum_good = sat_add(int'(r_acc_good[r_tgt]), w_eff_good, NEW_TOKENS_BITS);
      w_sum_bad  = sat_add(int'(r_acc_bad[r_tgt]), w_eff_bad, NEW_TOKENS_BITS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_src    <= '0;
         r_tgt    <= '0;
         r_neg    <= 1'b0;
         go_out   <= 1'b0;
         next_out <= 1'b0;
         enable   <= 1'b0;
         for (int i = 0; i < NUM_PROCESSORS; i++) begin
            r_acc_good[i]      <= '0;
            r_acc_bad[i]       <= '0;
            new_good_tokens[i] <= '0;
            new_bad_tokens[i]  <= '0;
         end
      end else begin
         go_out   <= 1'b0;
         next_out <= 1'b0;
         enable   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_in) begin
                  for (int i = 0; i < NUM_PROCESSORS; i++) begin
                     r_acc_good[i] <= '0;
                     r_acc_bad[i]  <= '0;
                  end
                  go_out  <= 1'b1;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (done_in) begin
                  new_good_tokens <= r_acc_good;
                  new_bad_tokens  <= r_acc_bad;
                  enable          <= 1'b1;
                  r_state         <= ST_FLUSH;
               end else if (hot_in) begin
                  // Exactly one of start/stop gives a nonzero sign; an
                  // out-of-range source is treated like a zero sign.
                  if ((int'(idx_in) < NUM_PROCESSORS) && (t_start_in ^ t_stop_in)) begin
                     r_src   <= idx_in;
                     r_neg   <= t_stop_in;
                     r_tgt   <= '0;
                     r_state <= ST_SCAN;
                  end else begin
                     next_out <= 1'b1;
                     r_state  <= ST_NEXT;
                  end
               end
            end
            ST_SCAN: begin
               r_acc_good[r_tgt] <= NEW_TOKENS_BITS'(w_sum_good);
               r_acc_bad[r_tgt]  <= NEW_TOKENS_BITS'(w_sum_bad);
               if (r_tgt == IDX_W'(NUM_PROCESSORS - 1)) begin
                  next_out <= 1'b1;
                  r_state  <= ST_NEXT;
               end else begin
                  r_tgt <= r_tgt + IDX_W'(1);
               end
            end
            ST_NEXT:  r_state <= ST_WAIT;
            ST_FLUSH: r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/tt_um_jleugeri_ttt_demux.md
# tt_um_jleugeri_ttt_demux

Consumer and scatter side of the processor event network. Drives the `go`/`next` handshake of the event multiplexer and receives one active source at a time (index plus start/stop flags). For each event it walks all targets and accumulates signed per-connection weights into saturating good/bad token counters. At the end of a scan round it publishes the counts with a one-cycle `enable` pulse.

## Interface
- `NUM_PROCESSORS`, 10: number of sources and targets; `IDX_W = $clog2(NUM_PROCESSORS)`.
- `NEW_TOKENS_BITS`, 4: signed width of each token counter.
- `WEIGHT_BITS`, 4: signed width of each stored weight.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_in` in 1: request a scan round; sampled only in IDLE.
- `go_out` out 1: one-cycle pulse that starts a mux scan.
- `next_out` out 1: one-cycle pulse that releases the current event.
- `hot_in` in 1: mux presents a valid event.
- `done_in` in 1: mux scan finished.
- `idx_in` in IDX_W: source index of the event.
- `t_start_in` in 1: start flag of the event.
- `t_stop_in` in 1: stop flag of the event.
- `prog_we` in 1: weight write strobe.
- `prog_src` in IDX_W: source index for the write.
- `prog_tgt` in IDX_W: target index for the write.
- `prog_good_w` in WEIGHT_BITS: signed good weight.
- `prog_bad_w` in WEIGHT_BITS: signed bad weight.
- `new_good_tokens[NUM_PROCESSORS]` out NEW_TOKENS_BITS: signed, registered.
- `new_bad_tokens[NUM_PROCESSORS]` out NEW_TOKENS_BITS: signed, registered.
- `enable` out 1: one-cycle pulse; token outputs are valid and updated.

## Operation
- States: IDLE, WAIT, SCAN, NEXT, FLUSH.
- IDLE
  - `start_in`=1: clear all accumulators, assert `go_out` on the next cycle, go to WAIT.
  - `prog_we`=1: write weights (src,tgt). `prog_we` is ignored in every other state.
- WAIT
  - `done_in`=1 goes to FLUSH. This takes priority over `hot_in`.
  - Otherwise `hot_in`=1 captures `idx_in` and sign = `t_start_in` − `t_stop_in` (+1, −1 or 0).
  - sign 0 (both flags or neither) goes to NEXT with no accumulation.
  - sign ≠ 0 sets tgt=0 and goes to SCAN.
- SCAN: one target per cycle.
  - acc_good[tgt] += sign·w_good[src][tgt]; acc_bad[tgt] likewise.
  - tgt==NUM_PROCESSORS−1 goes to NEXT; otherwise tgt++.
- NEXT: `next_out`=1 for exactly one cycle, then WAIT.
- FLUSH
  - Output registers load the accumulators on entry.
  - `enable`=1 for this single cycle, then IDLE.
- Arithmetic
  - Weight is sign-extended and negated for sign −1, then added with saturation to [−2^(NEW_TOKENS_BITS−1), 2^(NEW_TOKENS_BITS−1)−1]. Default range is −8..7.
  - Negating −2^(WEIGHT_BITS−1) saturates to max.
- `idx_in` ≥ NUM_PROCESSORS: treated as sign 0 (skip to NEXT).
- Outputs hold the last flushed values until the next FLUSH.

## Timing
- Reset values:
  - State IDLE; `go_out`, `next_out` and `enable` are 0.
  - All token outputs, accumulators and weights are 0.
- Reset mid-round aborts immediately. No `next_out` is issued afterwards.
- `go_out` is high in the cycle after `start_in` is sampled.
- Latency per hot event with sign ≠ 0: capture + NUM_PROCESSORS SCAN cycles + 1 NEXT cycle.
  - Event at cycle t gives `next_out` at t+NUM_PROCESSORS+1.
  - Sign 0 gives `next_out` at t+1.
- `hot_in`/`idx_in` are sampled only in WAIT. The mux must hold them until `next_out`.
- `done_in` in WAIT gives `enable` on the following cycle.
- A weight write is visible to any round started on the next cycle.

## Structure
- Shared package `tt_um_jleugeri_ttt_pkg` holds:
  - the state enum;
  - the `sat_add` function (signed saturating add, parameterised width);
  - `IDX_W` derivation.
- Sub-module `tt_um_jleugeri_ttt_weights` is the NUM_PROCESSORS² register file of good/bad weights.
  - One synchronous write port.
  - One combinational read port addressed by (src, tgt).
- The FSM, counters and accumulators stay in the top block.

## Test plan
- Reset, then `start_in` → `go_out` pulse 1 cycle later; `done_in` at once → `enable` pulse and all outputs 0.
- Weights w_good[2][5]=3, w_bad[2][5]=−2; one event idx=2 start=1.
  - `next_out` 11 cycles after capture.
  - After done: good[5]=3, bad[5]=−2, all other counters 0.
- Same weights, three start events on idx=2 in one round → good[5] saturates to 7; then one stop event → 4.
- Event with start=stop=1 → `next_out` 1 cycle after capture; counters unchanged.
- `done_in` and `hot_in` asserted in the same cycle → FLUSH taken, event ignored, no `next_out`.
- `rst_n` low during SCAN → all outputs and weights 0 asynchronously. A later round with no weights written yields all zeros.
